// File: rtl/instr_encoder.sv
// RV64I instruction encoder: packs request fields into a 32-bit word,
// substitutes a NOP for illegal requests and buffers the results in a
// two-entry output FIFO with a saturating illegal-request counter.
module instr_encoder #(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] instr_o,
  output logic        error_o,
  output logic [7:0]  err_count_o
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
  } fmt_e;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  occ_e        occ_q, occ_d;
  logic [31:0] head_instr_q, head_instr_d;
  logic        head_err_q, head_err_d;
  logic [31:0] tail_instr_q, tail_instr_d;
  logic        tail_err_q, tail_err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        rdy_en_q;

  fmt_e        fmt;
  logic [31:0] enc_word;
  logic        illegal;
  logic [31:0] new_instr;
  logic        push, pop;

  // Opcode decode, immediate range checks and field packing.
  always_comb begin
    fmt      = FMT_BAD;
    enc_word = '0;
    illegal  = 1'b0;
    unique case (opcode_i)
      7'h33, 7'h3B:                             fmt = FMT_R;
      7'h13, 7'h1B, 7'h03, 7'h67, 7'h0F, 7'h73: fmt = FMT_I;
      7'h23:                                    fmt = FMT_S;
      7'h63:                                    fmt = FMT_B;
      7'h37, 7'h17:                             fmt = FMT_U;
      7'h6F:                                    fmt = FMT_J;
      default:                                  fmt = FMT_BAD;
    endcase
    // A signed value fits in N bits when every bit above N-1 equals the sign.
    unique case (fmt)
      FMT_R: begin
        enc_word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      end
      FMT_I: begin
        illegal  = !((&imm_i[31:11]) || !(|imm_i[31:11]));
        enc_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
      end
      FMT_S: begin
        illegal  = !((&imm_i[31:11]) || !(|imm_i[31:11]));
        enc_word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
      end
      FMT_B: begin
        illegal  = !((&imm_i[31:12]) || !(|imm_i[31:12])) || imm_i[0];
        enc_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                    imm_i[4:1], imm_i[11], opcode_i};
      end
      FMT_U: begin
        illegal  = |imm_i[11:0];
        enc_word = {imm_i[31:12], rd_i, opcode_i};
      end
      FMT_J: begin
        illegal  = !((&imm_i[31:20]) || !(|imm_i[31:20])) || imm_i[0];
        enc_word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                    rd_i, opcode_i};
      end
      default: begin
        illegal  = 1'b1;
        enc_word = '0;
      end
    endcase
    new_instr = illegal ? NOP : enc_word;
  end

  assign ready_o     = rdy_en_q && (32'(occ_q) < FIFO_DEPTH);
  assign valid_o     = (occ_q != OCC_EMPTY);
  assign push        = valid_i && ready_o;
  assign pop         = valid_o && ready_i;
  assign instr_o     = head_instr_q;
  assign error_o     = head_err_q;
  assign err_count_o = err_cnt_q;

  // FIFO occupancy next-state and entry movement; the head entry is cleared
  // whenever the FIFO empties so the outputs read zero with no valid word.
  always_comb begin
    occ_d        = occ_q;
    head_instr_d = head_instr_q;
    head_err_d   = head_err_q;
    tail_instr_d = tail_instr_q;
    tail_err_d   = tail_err_q;
    unique case (occ_q)
      OCC_EMPTY: begin
        if (push) begin
          head_instr_d = new_instr;
          head_err_d   = illegal;
          occ_d        = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (push && pop) begin
          head_instr_d = new_instr;
          head_err_d   = illegal;
        end else if (push) begin
          tail_instr_d = new_instr;
          tail_err_d   = illegal;
          occ_d        = OCC_TWO;
        end else if (pop) begin
          head_instr_d = '0;
          head_err_d   = 1'b0;
          occ_d        = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        if (pop) begin
          head_instr_d = tail_instr_q;
          head_err_d   = tail_err_q;
          tail_instr_d = '0;
          tail_err_d   = 1'b0;
          occ_d        = OCC_ONE;
        end
      end
      default: begin
        occ_d        = OCC_EMPTY;
        head_instr_d = '0;
        head_err_d   = 1'b0;
      end
    endcase
  end

  // Saturating count of accepted illegal requests.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (push && illegal && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 8'd1;
  end

  // State registers; rdy_en_q holds ready_o low until the first edge after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      occ_q        <= OCC_EMPTY;
      head_instr_q <= '0;
      head_err_q   <= 1'b0;
      tail_instr_q <= '0;
      tail_err_q   <= 1'b0;
      err_cnt_q    <= '0;
      rdy_en_q     <= 1'b0;
    end else begin
      occ_q        <= occ_d;
      head_instr_q <= head_instr_d;
      head_err_q   <= head_err_d;
      tail_instr_q <= tail_instr_d;
      tail_err_q   <= tail_err_d;
      err_cnt_q    <= err_cnt_d;
      rdy_en_q     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed testbench for instr_encoder with hand-computed expected words.
module tb_instr_encoder;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [6:0]  opcode_i = '0;
  logic [4:0]  rd_i = '0;
  logic [4:0]  rs1_i = '0;
  logic [4:0]  rs2_i = '0;
  logic [2:0]  funct3_i = '0;
  logic [6:0]  funct7_i = '0;
  logic [31:0] imm_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] instr_o;
  logic        error_o;
  logic [7:0]  err_count_o;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  instr_encoder #(.FIFO_DEPTH(2)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .opcode_i    (opcode_i),
    .rd_i        (rd_i),
    .rs1_i       (rs1_i),
    .rs2_i       (rs2_i),
    .funct3_i    (funct3_i),
    .funct7_i    (funct7_i),
    .imm_i       (imm_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .instr_o     (instr_o),
    .error_o     (error_o),
    .err_count_o (err_count_o)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] imm);
    opcode_i = op; rd_i = rd; rs1_i = rs1; rs2_i = rs2;
    funct3_i = f3; funct7_i = f7; imm_i = imm;
    valid_i  = 1'b1;
  endtask

  // One request with ready_i high: word visible after one edge, gone after the next.
  task automatic one_vec(input string tag, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm,
                         input logic [31:0] exp_instr, input logic exp_err,
                         input logic [7:0] exp_cnt);
    drive(op, rd, rs1, rs2, f3, f7, imm);
    tick();
    valid_i = 1'b0;
    chk({tag, ".valid"}, 32'(valid_o), 32'd1);
    chk({tag, ".instr"}, instr_o, exp_instr);
    chk({tag, ".err"},   32'(error_o), 32'(exp_err));
    chk({tag, ".cnt"},   32'(err_count_o), 32'(exp_cnt));
    tick();
    chk({tag, ".drain"}, 32'(valid_o), 32'd0);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst.valid", 32'(valid_o), 32'd0);
    chk("rst.ready", 32'(ready_o), 32'd0);
    chk("rst.instr", instr_o, 32'd0);
    chk("rst.err",   32'(error_o), 32'd0);
    chk("rst.cnt",   32'(err_count_o), 32'd0);
    tick();
    reset_n = 1'b1;
    chk("rst.ready_hold", 32'(ready_o), 32'd0);
    tick();
    chk("rst.ready_rise", 32'(ready_o), 32'd1);
    chk("empty.instr", instr_o, 32'd0);

    ready_i = 1'b1;
    one_vec("add",     7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0,        32'h002081B3, 1'b0, 8'd0);
    one_vec("addi_m1", 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 32'hFFF00093, 1'b0, 8'd0);
    one_vec("beq_m4",  7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0, 8'd0);
    one_vec("jal_2k",  7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,     32'h001000EF, 1'b0, 8'd0);
    one_vec("sw_m8",   7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFFFFF8, 32'hFE20AC23, 1'b0, 8'd0);
    one_vec("auipc",   7'h17, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h12345297, 1'b0, 8'd0);
    one_vec("addi_mn", 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800, 32'h80000013, 1'b0, 8'd0);
    one_vec("jal_mn",  7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF00000, 32'h8000006F, 1'b0, 8'd0);
    one_vec("lui_bad", 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001001, 32'h00000013, 1'b1, 8'd1);
    one_vec("addi_ov", 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,     32'h00000013, 1'b1, 8'd2);
    one_vec("beq_odd", 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,        32'h00000013, 1'b1, 8'd3);
    one_vec("jal_ov",  7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00100000, 32'h00000013, 1'b1, 8'd4);

    // Backpressure: three back-to-back requests with the consumer stalled
    ready_i = 1'b0;
    drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    tick();
    chk("bp.ready1", 32'(ready_o), 32'd1);
    drive(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    tick();
    chk("bp.ready2", 32'(ready_o), 32'd0);
    drive(7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    chk("bp.headA", instr_o, 32'h00100093);
    tick();
    chk("bp.stable", instr_o, 32'h00100093);
    chk("bp.still_full", 32'(ready_o), 32'd0);
    ready_i = 1'b1;
    tick();
    chk("bp.headB", instr_o, 32'h00200113);
    chk("bp.ready3", 32'(ready_o), 32'd1);
    tick();
    valid_i = 1'b0;
    chk("bp.headC", instr_o, 32'h00300193);
    chk("bp.validC", 32'(valid_o), 32'd1);
    tick();
    chk("bp.empty", 32'(valid_o), 32'd0);
    chk("bp.cnt", 32'(err_count_o), 32'd4);

    // Saturation: 260 illegal opcodes on top of the 4 already counted
    drive(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    for (int unsigned k = 0; k < 260; k++) begin
      tick();
      if (k == 9) chk("sat.mid", 32'(err_count_o), 32'd14);
    end
    valid_i = 1'b0;
    chk("sat.cnt",   32'(err_count_o), 32'd255);
    chk("sat.err",   32'(error_o), 32'd1);
    chk("sat.instr", instr_o, 32'h00000013);
    tick();
    chk("sat.hold", 32'(err_count_o), 32'd255);

    // Reset pulse with two words buffered
    ready_i = 1'b0;
    drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    tick();
    drive(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    tick();
    valid_i = 1'b0;
    chk("rp.full", 32'(ready_o), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rp.valid", 32'(valid_o), 32'd0);
    chk("rp.cnt",   32'(err_count_o), 32'd0);
    chk("rp.instr", instr_o, 32'd0);
    chk("rp.ready", 32'(ready_o), 32'd0);
    tick();
    reset_n = 1'b1;
    ready_i = 1'b1;
    tick();
    chk("rp.ready_rise", 32'(ready_o), 32'd1);
    chk("rp.no_stale", 32'(valid_o), 32'd0);
    tick();
    chk("rp.no_stale2", 32'(valid_o), 32'd0);
    chk("rp.instr2", instr_o, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
